// File: rtl/core_pkg.sv
// Shared front-end types: datapath widths, the NOP filler word, fetch FSM states
// and the fetch-entry record carried from fetch to decode.
package core_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MISS = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetch entries toward decode. Flush empties it; flush with
// load leaves exactly one entry (the misaligned-exception record) in it.
module fetch_buffer
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  input  logic         load,
  input  fetch_entry_t load_entry,
  output fetch_entry_t head,
  output logic         valid,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [2];
  logic [1:0]   count;
  logic         rd_ptr;
  logic         wr_ptr;

  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);
  assign valid = !empty;
  assign head  = empty ? '0 : mem[rd_ptr];

  // When full, wr_ptr == rd_ptr: a push+pop overwrites the slot being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= load;
      count  <= load ? 2'd1 : 2'd0;
      if (load) mem[0] <= load_entry;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, captures icache hits into the
// decode buffer, and handles misses, backpressure and redirects.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 64'h0,
  parameter int              INSTR_BYTES = 4,
  parameter logic [ILEN-1:0] NOP_INSTR   = core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] PC,
  input  logic            icache_r,
  input  logic [ILEN-1:0] instruction,
  output logic            icache_miss,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            de_valid,
  input  logic            de_ready,
  output logic [XLEN-1:0] de_pc,
  output logic [ILEN-1:0] de_instruction,
  output logic            de_misaligned,
  output logic [31:0]     stall_cycles,
  output logic [1:0]      dbg_state
);

  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            buf_full, buf_empty;
  logic            pop, can_push, push, load_exc;
  fetch_entry_t    head, push_entry, exc_entry;

  // Handshake: an entry transfers to decode on a cycle where de_valid && de_ready,
  // unless a redirect in the same cycle flushes it (decode must drop it).
  assign pop        = de_valid && de_ready && !redirect_valid;
  assign can_push   = !buf_full || (de_valid && de_ready);
  assign load_exc   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign push_entry = '{pc: pc_q, instr: instruction, misaligned: 1'b0};
  assign exc_entry  = '{pc: redirect_pc, instr: NOP_INSTR, misaligned: 1'b1};

  assign PC             = pc_q;
  assign icache_miss    = (state_q == MISS);
  assign dbg_state      = state_q;
  assign de_valid       = !buf_empty;
  assign de_pc          = head.pc;
  assign de_instruction = head.instr;
  assign de_misaligned  = head.misaligned;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = load_exc ? HALT : RUN;
    end else begin
      case (state_q)
        RUN, MISS: begin
          if (icache_r) begin
            state_d = RUN;
            if (can_push) begin
              push = 1'b1;
              pc_d = pc_q + XLEN'(INSTR_BYTES);
            end
          end else begin
            state_d = MISS;
          end
        end
        default: state_d = HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == MISS && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .load       (load_exc),
    .load_entry (exc_entry),
    .head       (head),
    .valid      (),
    .full       (buf_full),
    .empty      (buf_empty)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-based fetch model compared
// every cycle, plus directed literal expectations.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] PC;
  logic        icache_r = 1'b0;
  logic [31:0] instruction = '0;
  logic        icache_miss;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        de_valid;
  logic        de_ready = 1'b0;
  logic [63:0] de_pc;
  logic [31:0] de_instruction;
  logic        de_misaligned;
  logic [31:0] stall_cycles;
  logic [1:0]  dbg_state;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PC             (PC),
    .icache_r       (icache_r),
    .instruction    (instruction),
    .icache_miss    (icache_miss),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .de_valid       (de_valid),
    .de_ready       (de_ready),
    .de_pc          (de_pc),
    .de_instruction (de_instruction),
    .de_misaligned  (de_misaligned),
    .stall_cycles   (stall_cycles),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model: expected queue of {pc, instr, misaligned}, fetch PC, halted/miss flags
  logic [96:0] exp_q[$];
  logic [63:0] m_pc;
  logic        m_halted;
  logic        m_in_miss;
  logic [31:0] m_stall;
  logic        check_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc = 64'h0;
    m_halted = 1'b0;
    m_in_miss = 1'b0;
    m_stall = '0;
  endtask

  task automatic model_update(input logic icr, input logic [31:0] ins, input logic rv,
                              input logic [63:0] rpc, input logic dr);
    logic take;
    if (m_in_miss && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (rv) begin
      exp_q.delete();
      m_pc = rpc;
      m_in_miss = 1'b0;
      m_halted = (rpc[1:0] != 2'b00);
      if (m_halted) exp_q.push_back({rpc, 32'h0000_0013, 1'b1});
      return;
    end
    take = (exp_q.size() > 0) && dr;
    if (m_halted) begin
      if (take) void'(exp_q.pop_front());
      return;
    end
    if (icr) begin
      m_in_miss = 1'b0;
      if (exp_q.size() < 2 || take) begin
        if (take) void'(exp_q.pop_front());
        exp_q.push_back({m_pc, ins, 1'b0});
        m_pc = m_pc + 64'd4;
      end
    end else begin
      m_in_miss = 1'b1;
      if (take) void'(exp_q.pop_front());
    end
  endtask

  // compare process: every negedge while enabled and out of reset
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      logic [96:0] h;
      h = (exp_q.size() > 0) ? exp_q[0] : '0;
      chk("pc", PC, m_pc);
      chk("de_valid", 64'(de_valid), 64'(exp_q.size() > 0));
      chk("de_pc", de_pc, h[96:33]);
      chk("de_instruction", 64'(de_instruction), 64'(h[32:1]));
      chk("de_misaligned", 64'(de_misaligned), 64'(h[0]));
      chk("icache_miss", 64'(icache_miss), 64'(m_in_miss));
      chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    end
  end

  // driver tasks
  function automatic logic [31:0] ins_for(input logic [63:0] pc);
    return 32'hA500_0000 ^ pc[31:0];
  endfunction

  task automatic step(input logic icr, input logic rv, input logic [63:0] rpc, input logic dr);
    logic [31:0] ins;
    ins = icr ? ins_for(m_pc) : 32'hDEAD_BEEF;
    icache_r = icr;
    instruction = ins;
    redirect_valid = rv;
    redirect_pc = rpc;
    de_ready = dr;
    @(posedge clk);
    model_update(icr, ins, rv, rpc, dr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    icache_r = 1'b0;
    redirect_valid = 1'b0;
    de_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    check_en = 1'b1;
    chk("reset_pc", PC, 64'h0);
    chk("reset_de_valid", 64'(de_valid), 64'h0);
    chk("reset_stall", 64'(stall_cycles), 64'h0);

    // streaming hits with decode ready
    step(1, 0, 0, 1);
    chk("t1_pc_after1", PC, 64'h4);
    chk("t1_de_pc0", de_pc, 64'h0);
    chk("t1_de_instr0", 64'(de_instruction), 64'hA500_0000);
    step(1, 0, 0, 1);
    chk("t1_de_pc4", de_pc, 64'h4);
    step(1, 0, 0, 1);
    chk("t1_pc_after3", PC, 64'hC);
    chk("t1_stall", 64'(stall_cycles), 64'h0);

    // backpressure: buffer fills, PC holds, then push while full
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t2_pc_hold", PC, 64'h8);
    chk("t2_head0", de_pc, 64'h0);
    step(1, 0, 0, 1);
    chk("t2_head4", de_pc, 64'h4);
    chk("t2_pc_c", PC, 64'hC);
    step(1, 0, 0, 1);
    chk("t2_head8", de_pc, 64'h8);
    chk("t2_pc_10", PC, 64'h10);

    // miss for five cycles at 0x10, then hit
    repeat (5) step(0, 0, 0, 1);
    chk("t3_miss", 64'(icache_miss), 64'h1);
    chk("t3_pc_hold", PC, 64'h10);
    step(1, 0, 0, 1);
    chk("t3_stall5", 64'(stall_cycles), 64'h5);
    chk("t3_pc14", PC, 64'h14);
    chk("t3_head10", de_pc, 64'h10);
    chk("t3_miss_clr", 64'(icache_miss), 64'h0);

    // redirect with a full buffer and a simultaneous hit
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 64'h1000, 1);
    chk("t4_empty", 64'(de_valid), 64'h0);
    chk("t4_pc", PC, 64'h1000);
    step(1, 0, 0, 1);
    chk("t4_resume", de_pc, 64'h1000);

    // misaligned redirect, halt, then aligned redirect resumes
    step(1, 1, 64'h1002, 0);
    chk("t5_valid", 64'(de_valid), 64'h1);
    chk("t5_pc", de_pc, 64'h1002);
    chk("t5_nop", 64'(de_instruction), 64'h13);
    chk("t5_mis", 64'(de_misaligned), 64'h1);
    repeat (3) step(1, 0, 0, 0);
    chk("t5_halt_pc", PC, 64'h1002);
    step(1, 0, 0, 1);
    chk("t5_drained", 64'(de_valid), 64'h0);
    step(1, 0, 0, 1);
    chk("t5_no_push", 64'(de_valid), 64'h0);
    step(1, 1, 64'h2000, 0);
    step(1, 0, 0, 0);
    chk("t5_run_pc", PC, 64'h2004);
    chk("t5_run_head", de_pc, 64'h2000);

    // async reset mid-MISS with a full buffer
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t6_pre_miss", 64'(icache_miss), 64'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_pc", PC, 64'h0);
    chk("t6_valid", 64'(de_valid), 64'h0);
    chk("t6_de_pc", de_pc, 64'h0);
    chk("t6_de_instr", 64'(de_instruction), 64'h0);
    chk("t6_miss", 64'(icache_miss), 64'h0);
    chk("t6_stall", 64'(stall_cycles), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // mixed traffic checked by the model
    for (int i = 0; i < 80; i++) begin
      logic rv;
      logic [63:0] rpc;
      rv = ($urandom_range(0, 7) == 0);
      rpc = 64'h4000 + 64'($urandom_range(0, 255));
      step(($urandom_range(0, 3) != 0), rv, rpc, ($urandom_range(0, 2) != 0));
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
